// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction fetch front end with a credit-limited request
// generator, an in-order grant-address tag FIFO and a DEPTH-entry instruction
// queue toward ID. Redirects flush the queue and discard in-flight responses.
//
// Optional feature: define IF_BYPASS_EN to let a response that meets an empty
// queue and a ready ID stage go straight to if_* without being queued.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   br_valid, br_target   redirect request and target PC from EX
//   mem_req, mem_addr     fetch request and address (addr 0 when idle)
//   mem_gnt               request accepted this cycle
//   mem_rvalid, mem_rdata in-order fetch response
//   if_valid, if_inst,    queue head toward ID (inst/pc 0 when not valid)
//   if_pc
//   id_ready              ID consumes the head this cycle
//   fq_count              number of valid queue entries
module if_fetch_queue #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INST_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     br_valid,
    input  logic [ADDR_W-1:0]        br_target,
    output logic                     mem_req,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic                     mem_gnt,
    input  logic                     mem_rvalid,
    input  logic [INST_W-1:0]        mem_rdata,
    output logic                     if_valid,
    output logic [INST_W-1:0]        if_inst,
    output logic [ADDR_W-1:0]        if_pc,
    input  logic                     id_ready,
    output logic [$clog2(DEPTH):0]   fq_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W+1)'(DEPTH);

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [CNT_W-1:0]  r_outst;
    logic [CNT_W-1:0]  r_drop;
    logic [CNT_W-1:0]  w_drop_nxt;
    logic [CNT_W-1:0]  r_q_wptr;
    logic [CNT_W-1:0]  r_q_rptr;
    logic [CNT_W-1:0]  r_t_wptr;
    logic [CNT_W-1:0]  r_t_rptr;
    logic [INST_W-1:0] r_q_inst [DEPTH];
    logic [ADDR_W-1:0] r_q_pc   [DEPTH];
    logic [ADDR_W-1:0] r_t_pc   [DEPTH];

    logic [CNT_W-1:0]  w_count;
    logic              w_q_empty;
    logic              w_credit_ok;
    logic              w_req;
    logic              w_grant;
    logic              w_resp;
    logic              w_resp_keep;
    logic              w_bypass;
    logic              w_head_valid;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_tag_pc;

    // Occupancy and request credit: outstanding requests reserve queue slots.
    assign w_count     = r_q_wptr - r_q_rptr;
    assign w_q_empty   = (w_count == '0);
    assign w_credit_ok = ((CNT_W+1)'(r_outst) + (CNT_W+1)'(w_count)) < DEPTH_L;
    assign w_req       = (r_state == ST_RUN) && !br_valid && w_credit_ok;
    assign w_grant     = w_req && mem_gnt;

    // A response with nothing outstanding is illegal and ignored entirely.
    assign w_resp      = mem_rvalid && (r_outst != '0);
    assign w_resp_keep = w_resp && (r_drop == '0) && !br_valid && (r_state == ST_RUN);
    assign w_tag_pc    = r_t_pc[r_t_rptr[PTR_W-1:0]];

`ifdef IF_BYPASS_EN
    assign w_bypass = w_resp_keep && w_q_empty && id_ready;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_head_valid = !w_q_empty && !br_valid;
    assign w_pop        = w_head_valid && id_ready;
    assign w_push       = w_resp_keep && !w_bypass;

    assign mem_req  = w_req;
    assign mem_addr = w_req ? r_pc : '0;
    assign if_valid = w_head_valid || w_bypass;
    assign if_inst  = w_bypass     ? mem_rdata :
                      w_head_valid ? r_q_inst[r_q_rptr[PTR_W-1:0]] : '0;
    assign if_pc    = w_bypass     ? w_tag_pc :
                      w_head_valid ? r_q_pc[r_q_rptr[PTR_W-1:0]] : '0;
    assign fq_count = w_count;

    // Responses still owed to discarded requests after a redirect.
    always_comb begin
        w_drop_nxt = r_drop;
        if (br_valid) begin
            w_drop_nxt = r_outst - CNT_W'(w_resp);
        end else if (w_resp && (r_drop != '0)) begin
            w_drop_nxt = r_drop - CNT_W'(1);
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_BOOT:  w_state_nxt = ST_RUN;
            ST_RUN:   if (br_valid && (w_drop_nxt != '0)) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_drop_nxt == '0) w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_BOOT;
        endcase
    end

    // State, PC, credit and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_BOOT;
            r_pc     <= RESET_PC;
            r_outst  <= '0;
            r_drop   <= '0;
            r_q_wptr <= '0;
            r_q_rptr <= '0;
            r_t_wptr <= '0;
            r_t_rptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_drop  <= w_drop_nxt;
            if (br_valid) begin
                r_pc <= br_target;
            end else if (w_grant) begin
                r_pc <= r_pc + ADDR_W'(4);
            end
            r_outst <= r_outst + CNT_W'(w_grant) - CNT_W'(w_resp);
            if (br_valid) begin
                r_q_rptr <= r_q_wptr;
                r_t_rptr <= r_t_wptr;
            end else begin
                if (w_push)  r_q_wptr <= r_q_wptr + CNT_W'(1);
                if (w_pop)   r_q_rptr <= r_q_rptr + CNT_W'(1);
                if (w_grant) r_t_wptr <= r_t_wptr + CNT_W'(1);
                // Tags of kept responses retire in order; dropped ones were flushed.
                if (w_resp && (r_drop == '0)) r_t_rptr <= r_t_rptr + CNT_W'(1);
            end
        end
    end

    // Queue and tag storage; validity is tracked by the pointers only.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_inst[r_q_wptr[PTR_W-1:0]] <= mem_rdata;
            r_q_pc[r_q_wptr[PTR_W-1:0]]   <= w_tag_pc;
        end
        if (w_grant) begin
            r_t_pc[r_t_wptr[PTR_W-1:0]] <= r_pc;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        br_valid = 1'b0;
    logic [31:0] br_target = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        id_ready = 1'b0;
    logic [2:0]  fq_count;

    int total = 0;
    int bad = 0;

    logic [31:0] pend[$];
    logic [31:0] gnt_addr[$];
    logic [31:0] obs_pc[$];
    logic [31:0] obs_inst[$];
    bit gnt_on, resp_en, rdy;
    logic        s_req, s_ival;
    logic [31:0] s_addr;

    if_fetch_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_target(br_target),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .if_valid(if_valid),
        .if_inst(if_inst), .if_pc(if_pc), .id_ready(id_ready), .fq_count(fq_count)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 'x;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at posedge+1, sample at negedge, return at posedge+1.
    task automatic cycle(input bit br = 1'b0, input logic [31:0] tgt = 32'h0);
        br_valid  = br;
        br_target = tgt;
        mem_gnt   = gnt_on;
        id_ready  = rdy;
        if (resp_en && pend.size() > 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = memf(pend.pop_front());
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
        end
        @(negedge clk);
        s_req  = mem_req;
        s_addr = mem_addr;
        s_ival = if_valid;
        if (mem_req && mem_gnt) begin
            gnt_addr.push_back(mem_addr);
            pend.push_back(mem_addr);
        end
        if (if_valid && id_ready) begin
            obs_pc.push_back(if_pc);
            obs_inst.push_back(if_inst);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        gnt_addr.delete();
        obs_pc.delete();
        obs_inst.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        br_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; id_ready = 1'b0;
        gnt_on = 1'b0; resp_en = 1'b0; rdy = 1'b0;
        pend.delete();
        clear_logs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic three_grants();
        int guard;
        gnt_on = 1'b1; resp_en = 1'b0; rdy = 1'b1;
        cycle();
        guard = 0;
        while (gnt_addr.size() < 3 && guard < 20) begin
            cycle();
            guard++;
        end
        gnt_on = 1'b0;
        chk("three_grants", 64'(gnt_addr.size()), 64'd3);
    endtask

    initial begin
        int hits;
        // Reset values while rst_n is held low.
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_mem_req",  64'(mem_req),  64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_if_valid", 64'(if_valid), 64'd0);
        chk("rst_if_inst",  64'(if_inst),  64'd0);
        chk("rst_if_pc",    64'(if_pc),    64'd0);
        chk("rst_fq_count", 64'(fq_count), 64'd0);

        // Streaming fetch: BOOT cycle, first request in cycle 2, 1-cycle queue latency.
        do_reset();
        gnt_on = 1'b1; resp_en = 1'b1; rdy = 1'b1;
        cycle();
        chk("boot_no_req", 64'(s_req), 64'd0);
        cycle();
        chk("first_req",  64'(s_req),  64'd1);
        chk("first_addr", 64'(s_addr), 64'd0);
        cycle();
        chk("resp_cycle_ivalid", 64'(s_ival), 64'd0);
        cycle();
        chk("head_cycle_ivalid", 64'(s_ival), 64'd1);
        repeat (10) cycle();
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("stream_pc%0d", i),   64'(qat(obs_pc, i)),   64'(32'(4 * i)));
            chk($sformatf("stream_inst%0d", i), 64'(qat(obs_inst, i)), 64'(memf(32'(4 * i))));
        end

        // ID stalled: credit limits grants to DEPTH, queue fills, then resumes in order.
        do_reset();
        gnt_on = 1'b1; resp_en = 1'b1; rdy = 1'b0;
        repeat (12) cycle();
        chk("stall_grants", 64'(gnt_addr.size()), 64'd4);
        chk("stall_req",    64'(s_req),           64'd0);
        chk("stall_count",  64'(fq_count),        64'd4);
        chk("stall_nopop",  64'(obs_pc.size()),   64'd0);
        rdy = 1'b1;
        repeat (12) cycle();
        for (int i = 0; i < 6; i++)
            chk($sformatf("resume_pc%0d", i), 64'(qat(obs_pc, i)), 64'(32'(4 * i)));

        // Redirect with 3 outstanding: drain 3 responses, restart at 0x100.
        do_reset();
        three_grants();
        cycle(1'b1, 32'h100);
        chk("br_req_forced",    64'(s_req),    64'd0);
        chk("br_ivalid_forced", 64'(s_ival),   64'd0);
        chk("br_flush_count",   64'(fq_count), 64'd0);
        gnt_on = 1'b1;
        cycle();
        chk("drain_no_req", 64'(s_req), 64'd0);
        clear_logs();
        resp_en = 1'b1;
        cycle();
        chk("drain_resp1_no_req", 64'(s_req), 64'd0);
        repeat (12) cycle();
        chk("redir_gnt0",  64'(qat(gnt_addr, 0)), 64'h100);
        chk("redir_pc0",   64'(qat(obs_pc, 0)),   64'h100);
        chk("redir_pc1",   64'(qat(obs_pc, 1)),   64'h104);
        chk("redir_inst0", 64'(qat(obs_inst, 0)), 64'(memf(32'h100)));

        // Second redirect during DRAIN: nothing from 0x100 is fetched or emitted.
        do_reset();
        three_grants();
        cycle(1'b1, 32'h100);
        resp_en = 1'b1;
        cycle();
        cycle(1'b1, 32'h200);
        gnt_on = 1'b1;
        clear_logs();
        repeat (12) cycle();
        hits = 0;
        foreach (obs_pc[i]) if (obs_pc[i][31:8] == 24'h1) hits++;
        foreach (gnt_addr[i]) if (gnt_addr[i][31:8] == 24'h1) hits++;
        chk("redir2_no_0x100", 64'(hits), 64'd0);
        chk("redir2_gnt0", 64'(qat(gnt_addr, 0)), 64'h200);
        chk("redir2_pc0",  64'(qat(obs_pc, 0)),   64'h200);

        // Redirect during BOOT to the top of the address space, then wrap to 0.
        do_reset();
        gnt_on = 1'b1; resp_en = 1'b1; rdy = 1'b1;
        cycle(1'b1, 32'hFFFF_FFFC);
        repeat (8) cycle();
        chk("wrap_gnt0", 64'(qat(gnt_addr, 0)), 64'hFFFF_FFFC);
        chk("wrap_gnt1", 64'(qat(gnt_addr, 1)), 64'h0);
        chk("wrap_pc0",  64'(qat(obs_pc, 0)),   64'hFFFF_FFFC);
        chk("wrap_pc1",  64'(qat(obs_pc, 1)),   64'h0);
        chk("wrap_pc2",  64'(qat(obs_pc, 2)),   64'h4);

        // Asynchronous reset mid-burst: outputs clear at once, fetch restarts at 0.
        do_reset();
        gnt_on = 1'b1; resp_en = 1'b1; rdy = 1'b0;
        repeat (6) cycle();
        chk("pre_rst_ivalid", 64'(if_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mem_req",  64'(mem_req),  64'd0);
        chk("mid_rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("mid_rst_if_valid", 64'(if_valid), 64'd0);
        chk("mid_rst_if_inst",  64'(if_inst),  64'd0);
        chk("mid_rst_if_pc",    64'(if_pc),    64'd0);
        chk("mid_rst_fq_count", 64'(fq_count), 64'd0);
        do_reset();
        gnt_on = 1'b1; resp_en = 1'b1; rdy = 1'b1;
        repeat (8) cycle();
        chk("restart_gnt0", 64'(qat(gnt_addr, 0)), 64'h0);
        chk("restart_pc0",  64'(qat(obs_pc, 0)),   64'h0);
        chk("restart_pc1",  64'(qat(obs_pc, 1)),   64'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
